hazard_controller: RTL
======================

# hazard_controller

Pipeline hazard controller for the 5-stage MIPS-Lite core. It tracks the destination tags of the instructions in EX, MEM and WB, and drives the registered forwarding selects consumed by the execution stage's operand muxes. It also produces the stall, bubble and flush controls for PC, IF/ID and ID/EX, and sequences the pipeline drain on HALT. It sits beside the decode stage and takes its inputs from decode and from the execution stage's branch outcome.

## Interface
- REGBITS, 5, register-index width
- CNTW, 16, width of the saturating event counters

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  REGBITS  source indices of the decode instruction
- id_uses_rs, id_uses_rt  in  1  source actually read
- id_dest  in  REGBITS  destination index
- id_writes  in  1  instruction writes the register file
- id_is_load  in  1  LDW
- id_is_halt  in  1  HALT
- ex_branch_taken  in  1  taken branch or jump resolved in EX this cycle
- forward1, forward2  out  1  select EX/MEM aluOut for operand 1 / 2
- memForward1, memForward2  out  1  select MEM/WB data
- wbForward1, wbForward2  out  1  select WB write data
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- idex_bubble  out  1  load a NOP into ID/EX
- ifid_flush  out  1  squash IF/ID
- pc_load  out  1  PC takes branch target
- halted  out  1  pipeline fully drained after HALT
- stall_count, flush_count  out  CNTW  saturating event counters

## Operation
- Tag pipeline: three entries, EX, MEM and WB. Each entry holds {valid, dest, writes, load, halt}.
- Tag pipeline shifts every cycle: WB←MEM, MEM←EX. EX←decode fields when decode advances, else an invalid bubble.
- A tag matches a source when all hold: entry valid, writes=1, dest≠0, dest==source, and the source is used.
- Forward selects are registered and computed for the instruction entering EX:
  - match on the EX tag → forward*
  - else match on the MEM tag → memForward*
  - else match on the WB tag → wbForward*
- Newest producer wins; at most one select per operand is high. All selects are 0 when EX receives a bubble.
- Load-use: an EX tag with load=1 matching a used source gives a 1-cycle stall. pc_stall=ifid_stall=idex_bubble=1 and stall_count+1. On the retry the load sits in MEM, so memForward* is selected.
- Branch: ex_branch_taken gives pc_load=ifid_flush=idex_bubble=1 and flush_count+1. A branch overrides a simultaneous load-use stall (pc_stall=ifid_stall=0), and that stall is not counted.
- FSM states:
  - RUN: normal operation. id_is_halt with id_valid and no branch → halt advances into EX, go to DRAIN.
  - DRAIN: pc_stall=ifid_stall=idex_bubble=1. When the WB tag has halt=1, go to HALTED.
  - HALTED: sticky; halted=1, pc_stall=ifid_stall=idex_bubble=1. Exits only on reset.
- HALT in decode with ex_branch_taken: the branch wins, HALT is squashed, and the FSM stays in RUN.
- Counters saturate at 2^CNTW−1. DRAIN and HALTED cycles are not counted as stalls.

## Timing
- Reset (synchronous, next edge):
  - all tags invalid and FSM in RUN
  - all forward selects, pc_load, ifid_flush and halted = 0
  - both counters = 0
- Reset wins over every other input, including in DRAIN or HALTED.
- Stall, bubble, flush and pc_load are combinational from the current tags and decode inputs, and are valid in the same cycle.
- Forward selects are registered, with 1-cycle latency: they are valid for the whole cycle the instruction occupies EX.
- HALT timing:
  - decode at cycle t, then DRAIN from t+1
  - HALT occupies the WB tag at t+3
  - halted=1 from t+4
- Decode inputs are ignored (treated as invalid) while in DRAIN or HALTED.

## Structure
- mips_pkg gets:
  - struct HazTag {valid, dest, writes, load, halt}
  - enum HazState {RUN, DRAIN, HALTED}
  - REGBITS and CNTW constants
- One sub-module, hazard_match: combinational tag-vs-source comparator, instantiated once per (stage, operand) pair (6 instances).
- FSM, tag shift register, forward registers and counters live in hazard_controller.

## Test plan
- ADD r3 then SUB r5,r3,r4 back-to-back → forward1=1 in SUB's EX cycle; all other selects 0, no stall.
- ADD r3, NOP, ADD r6,r1,r3 → memForward2=1 only. With two NOPs between → wbForward2=1 only.
- LDW r2 then ADD r7,r2,r2 → one cycle of pc_stall=ifid_stall=idex_bubble=1, stall_count=1. On retry memForward1=memForward2=1.
- ex_branch_taken coincident with a load-use condition → pc_load=ifid_flush=idex_bubble=1, pc_stall=0, flush_count=1, stall_count=0.
- Write to r0 followed by a read of r0 → no forward select and no stall. Two writers of r4 in EX and MEM → only forward* asserted.
- HALT decoded at cycle 10 → DRAIN cycles 11-13, halted=1 from cycle 14 and held. Reset at cycle 20 → halted=0, counters=0 at cycle 21.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS-Lite hazard controller.
// Tag layout, controller FSM states and a saturating-increment helper.
package mips_pkg;

  localparam int unsigned REGBITS = 5;
  localparam int unsigned CNTW    = 16;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic               valid;
    logic [REGBITS-1:0] dest;
    logic               writes;
    logic               load;
    logic               halt;
  } HazTag;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } HazState;

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] value,
                                              input logic             en);
    return (en && (value != '1)) ? value + CNTW'(1) : value;
  endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// Decode-side and execution-side hazard signals bundled for the hazard controller.
// The master drives decode fields and branch outcome; the slave returns pipeline controls.
interface hazard_controller_if;
  import mips_pkg::*;

  logic               id_valid;
  logic [REGBITS-1:0] id_rs;
  logic [REGBITS-1:0] id_rt;
  logic               id_uses_rs;
  logic               id_uses_rt;
  logic [REGBITS-1:0] id_dest;
  logic               id_writes;
  logic               id_is_load;
  logic               id_is_halt;
  logic               ex_branch_taken;

  logic               forward1;
  logic               forward2;
  logic               memForward1;
  logic               memForward2;
  logic               wbForward1;
  logic               wbForward2;
  logic               pc_stall;
  logic               ifid_stall;
  logic               idex_bubble;
  logic               ifid_flush;
  logic               pc_load;
  logic               halted;
  logic [CNTW-1:0]    stall_count;
  logic [CNTW-1:0]    flush_count;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_writes,
           id_is_load, id_is_halt, ex_branch_taken,
    input  forward1, forward2, memForward1, memForward2, wbForward1, wbForward2,
           pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_load, halted,
           stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dest, id_writes,
           id_is_load, id_is_halt, ex_branch_taken,
    output forward1, forward2, memForward1, memForward2, wbForward1, wbForward2,
           pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_load, halted,
           stall_count, flush_count
  );

endinterface

// File: rtl/hazard_match.sv
// Combinational comparator: does a pipeline tag produce the register a source reads?
// r0 is hardwired to zero, so writers of r0 never match.
module hazard_match
  import mips_pkg::*;
(
  input  logic               valid,
  input  logic               writes,
  input  logic [REGBITS-1:0] dest,
  input  logic [REGBITS-1:0] src,
  input  logic               used,
  output logic               hit
);

  assign hit = valid & writes & used & (dest != '0) & (dest == src);

endmodule

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage MIPS-Lite core: tag pipeline, registered forward
// selects, load-use stall, branch flush, HALT drain sequencing and event counters.
module hazard_controller
  import mips_pkg::*;
(
  input logic                clk,
  input logic                reset,
  hazard_controller_if.slave hz
);

  localparam int unsigned StEx  = 0;
  localparam int unsigned StMem = 1;
  localparam int unsigned StWb  = 2;

  HazTag           tag_q [3];
  HazTag           ex_d;
  HazState         state_q;

  logic            run;
  logic            dec_valid;
  logic            branch;
  logic            load_use;
  logic            advance;

  logic            hit_ex_rs, hit_ex_rt;
  logic            hit_mem_rs, hit_mem_rt;
  logic            hit_wb_rs, hit_wb_rt;

  // Bit 0 is operand 1 (rs), bit 1 is operand 2 (rt).
  logic [1:0]      fwd_ex_d, fwd_mem_d, fwd_wb_d;
  logic [1:0]      fwd_ex_q, fwd_mem_q, fwd_wb_q;

  logic [CNTW-1:0] stall_cnt_q;
  logic [CNTW-1:0] flush_cnt_q;

  assign run       = (state_q == RUN);
  assign dec_valid = run & hz.id_valid;
  assign branch    = run & hz.ex_branch_taken;

  hazard_match u_match_ex_rs (
    .valid  (tag_q[StEx].valid),
    .writes (tag_q[StEx].writes),
    .dest   (tag_q[StEx].dest),
    .src    (hz.id_rs),
    .used   (hz.id_uses_rs),
    .hit    (hit_ex_rs)
  );

  hazard_match u_match_ex_rt (
    .valid  (tag_q[StEx].valid),
    .writes (tag_q[StEx].writes),
    .dest   (tag_q[StEx].dest),
    .src    (hz.id_rt),
    .used   (hz.id_uses_rt),
    .hit    (hit_ex_rt)
  );

  hazard_match u_match_mem_rs (
    .valid  (tag_q[StMem].valid),
    .writes (tag_q[StMem].writes),
    .dest   (tag_q[StMem].dest),
    .src    (hz.id_rs),
    .used   (hz.id_uses_rs),
    .hit    (hit_mem_rs)
  );

  hazard_match u_match_mem_rt (
    .valid  (tag_q[StMem].valid),
    .writes (tag_q[StMem].writes),
    .dest   (tag_q[StMem].dest),
    .src    (hz.id_rt),
    .used   (hz.id_uses_rt),
    .hit    (hit_mem_rt)
  );

  hazard_match u_match_wb_rs (
    .valid  (tag_q[StWb].valid),
    .writes (tag_q[StWb].writes),
    .dest   (tag_q[StWb].dest),
    .src    (hz.id_rs),
    .used   (hz.id_uses_rs),
    .hit    (hit_wb_rs)
  );

  hazard_match u_match_wb_rt (
    .valid  (tag_q[StWb].valid),
    .writes (tag_q[StWb].writes),
    .dest   (tag_q[StWb].dest),
    .src    (hz.id_rt),
    .used   (hz.id_uses_rt),
    .hit    (hit_wb_rt)
  );

  // Load data is not ready until MEM, so a load in EX feeding decode costs one cycle.
  assign load_use = dec_valid & tag_q[StEx].load & (hit_ex_rs | hit_ex_rt);
  assign advance  = dec_valid & ~load_use & ~branch;

  always_comb begin
    ex_d = '0;
    if (advance) begin
      ex_d.valid  = 1'b1;
      ex_d.dest   = hz.id_dest;
      ex_d.writes = hz.id_writes;
      ex_d.load   = hz.id_is_load;
      ex_d.halt   = hz.id_is_halt;
    end
  end

  // Newest producer wins: older stages are masked by any younger match.
  always_comb begin
    fwd_ex_d  = '0;
    fwd_mem_d = '0;
    fwd_wb_d  = '0;
    if (advance) begin
      fwd_ex_d  = {hit_ex_rt, hit_ex_rs};
      fwd_mem_d = {hit_mem_rt & ~hit_ex_rt, hit_mem_rs & ~hit_ex_rs};
      fwd_wb_d  = {hit_wb_rt & ~hit_ex_rt & ~hit_mem_rt,
                   hit_wb_rs & ~hit_ex_rs & ~hit_mem_rs};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q[StEx]  <= '0;
      tag_q[StMem] <= '0;
      tag_q[StWb]  <= '0;
      fwd_ex_q     <= '0;
      fwd_mem_q    <= '0;
      fwd_wb_q     <= '0;
    end else begin
      tag_q[StWb]  <= tag_q[StMem];
      tag_q[StMem] <= tag_q[StEx];
      tag_q[StEx]  <= ex_d;
      fwd_ex_q     <= fwd_ex_d;
      fwd_mem_q    <= fwd_mem_d;
      fwd_wb_q     <= fwd_wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      unique case (state_q)
        RUN:     if (advance && hz.id_is_halt) state_q <= DRAIN;
        DRAIN:   if (tag_q[StWb].valid && tag_q[StWb].halt) state_q <= HALTED;
        HALTED:  state_q <= HALTED;
        default: state_q <= RUN;
      endcase
    end
  end

  // A branch squashes the stalled instruction, so that stall is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= sat_inc(stall_cnt_q, load_use & ~branch);
      flush_cnt_q <= sat_inc(flush_cnt_q, branch);
    end
  end

  assign hz.pc_stall    = ~run | (load_use & ~branch);
  assign hz.ifid_stall  = ~run | (load_use & ~branch);
  assign hz.idex_bubble = ~run | load_use | branch;
  assign hz.ifid_flush  = branch;
  assign hz.pc_load     = branch;
  assign hz.halted      = (state_q == HALTED);

  assign hz.forward1    = fwd_ex_q[0];
  assign hz.forward2    = fwd_ex_q[1];
  assign hz.memForward1 = fwd_mem_q[0];
  assign hz.memForward2 = fwd_mem_q[1];
  assign hz.wbForward1  = fwd_wb_q[0];
  assign hz.wbForward2  = fwd_wb_q[1];

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule
